// File: rtl/root_hub_router_pkg.sv
// Shared types and helpers for the root hub router: destination extraction
// and classification of master-side messages.
package hub_router_pkg;

  localparam int unsigned MAX_W            = 256;
  localparam int unsigned MAX_ID           = 16;
  localparam int unsigned DEF_FIFO_IDWIDTH = 4;
  localparam logic [DEF_FIFO_IDWIDTH-1:0] BROADCAST_ID = {DEF_FIFO_IDWIDTH{1'b1}};

  typedef enum logic [1:0] {
    DEST_BCAST = 2'd0,
    DEST_UNI   = 2'd1,
    DEST_BAD   = 2'd2
  } dest_kind_e;

  // Field [w-1:w-d] of msg, returned zero-extended so callers can size it.
  function automatic logic [MAX_W-1:0] dest_of(input logic [MAX_W-1:0] msg,
                                               input int unsigned w,
                                               input int unsigned d);
    return (msg >> (w - d)) & ((MAX_W'(1'b1) << d) - MAX_W'(1'b1));
  endfunction

  function automatic dest_kind_e dest_class(input logic [MAX_ID-1:0] dest,
                                            input int unsigned n,
                                            input int unsigned d);
    dest_kind_e kind;
    if (dest == ((MAX_ID'(1'b1) << d) - MAX_ID'(1'b1))) begin
      kind = DEST_BCAST;
    end else if (32'(dest) < n) begin
      kind = DEST_UNI;
    end else begin
      kind = DEST_BAD;
    end
    return kind;
  endfunction

endpackage

// File: rtl/root_hub_router_if.sv
// Bundle of the master-side and downstream-side buses of the root hub router.
// The slave modport is the router's view, master is the surrounding system.
interface root_hub_router_if #(
  parameter int DOWNSTREAM_FIFO_COUNT = 4,
  parameter int HUB_FIFO_WIDTH        = 32,
  parameter int DROP_COUNT_WIDTH      = 8
);

  logic [HUB_FIFO_WIDTH-1:0]                       up_in_data;
  logic                                            up_in_valid;
  logic                                            up_in_ready;
  logic [HUB_FIFO_WIDTH-1:0]                       up_out_data;
  logic                                            up_out_valid;
  logic                                            up_out_ready;
  logic [DOWNSTREAM_FIFO_COUNT*HUB_FIFO_WIDTH-1:0] ds_out_data;
  logic [DOWNSTREAM_FIFO_COUNT-1:0]                ds_out_valid;
  logic [DOWNSTREAM_FIFO_COUNT-1:0]                ds_out_ready;
  logic [DOWNSTREAM_FIFO_COUNT*HUB_FIFO_WIDTH-1:0] ds_in_data;
  logic [DOWNSTREAM_FIFO_COUNT-1:0]                ds_in_valid;
  logic [DOWNSTREAM_FIFO_COUNT-1:0]                ds_in_ready;
  logic [DOWNSTREAM_FIFO_COUNT-1:0]                ds_has_message_flying;
  logic [DOWNSTREAM_FIFO_COUNT-1:0]                ds_has_odd_clusters;
  logic                                            has_message_flying;
  logic                                            has_odd_clusters;
  logic                                            bad_dest;
  logic [DROP_COUNT_WIDTH-1:0]                     drop_count;

  modport slave (
    input  up_in_data, up_in_valid, up_out_ready,
    input  ds_out_ready, ds_in_data, ds_in_valid,
    input  ds_has_message_flying, ds_has_odd_clusters,
    output up_in_ready, up_out_data, up_out_valid,
    output ds_out_data, ds_out_valid, ds_in_ready,
    output has_message_flying, has_odd_clusters, bad_dest, drop_count
  );

  modport master (
    output up_in_data, up_in_valid, up_out_ready,
    output ds_out_ready, ds_in_data, ds_in_valid,
    output ds_has_message_flying, ds_has_odd_clusters,
    input  up_in_ready, up_out_data, up_out_valid,
    input  ds_out_data, ds_out_valid, ds_in_ready,
    input  has_message_flying, has_odd_clusters, bad_dest, drop_count
  );

endinterface

// File: rtl/root_hub_router_rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting at pointer and
// issues a one-hot grant only when advance allows a transfer.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic          advance,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  int   cand_s;
  logic found_s;
  logic hit_s;

  // Rotating first-requester search; the first hit blocks all later ones.
  always_comb begin
    grant     = {N{1'b0}};
    grant_idx = {IW{1'b0}};
    found_s   = 1'b0;
    hit_s     = 1'b0;
    cand_s    = 0;
    for (int k = 0; k < N; k++) begin
      cand_s = (int'(pointer) + k) % N;
      for (int j = 0; j < N; j++) begin
        hit_s     = advance && !found_s && req[j] && (cand_s == j);
        grant[j]  = grant[j] | hit_s;
        grant_idx = hit_s ? IW'(j) : grant_idx;
        found_s   = found_s | hit_s;
      end
    end
  end

endmodule

// File: rtl/root_hub_router.sv
// Root-level message hub: routes master messages to N downstream channels
// (broadcast/unicast/drop) and merges downstream messages back round-robin.
module root_hub_router
  import hub_router_pkg::*;
#(
  parameter int DOWNSTREAM_FIFO_COUNT = 4,
  parameter int HUB_FIFO_WIDTH        = 32,
  parameter int FIFO_IDWIDTH          = 4,
  parameter int DROP_COUNT_WIDTH      = 8
) (
  input logic         clk,
  input logic         reset,
  root_hub_router_if.slave bus
);

  localparam int N  = DOWNSTREAM_FIFO_COUNT;
  localparam int W  = HUB_FIFO_WIDTH;
  localparam int D  = FIFO_IDWIDTH;
  localparam int DC = DROP_COUNT_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0]  PAYLOAD_MASK = {{D{1'b0}}, {(W-D){1'b1}}};
  localparam logic [DC-1:0] DROP_MAX     = {DC{1'b1}};

  logic [D-1:0]   dest_s;
  dest_kind_e     kind_s;
  logic [N-1:0]   can_acc_s;
  logic [N-1:0]   uni_hit_s;
  logic [N-1:0]   load_s;
  logic           in_ready_s;
  logic           up_xfer_s;
  logic           drop_s;
  logic [N-1:0]   out_valid_r;
  logic [N*W-1:0] out_data_r;
  logic           bad_dest_r;
  logic [DC-1:0]  drop_count_r;

  logic [IW-1:0]  ptr_r;
  logic [IW-1:0]  grant_idx_s;
  logic [N-1:0]   grant_s;
  logic           up_can_acc_s;
  logic [W-1:0]   sel_data_s;
  logic [W-1:0]   tagged_s;
  logic           up_valid_r;
  logic [W-1:0]   up_data_r;
  logic           flying_r;
  logic           odd_r;

  // Outbound routing decision; a broadcast is accepted only if every channel can take it.
  always_comb begin
    dest_s    = D'(dest_of(MAX_W'(bus.up_in_data), W, D));
    kind_s    = dest_class(MAX_ID'(dest_s), N, D);
    can_acc_s = ~out_valid_r | bus.ds_out_ready;
    uni_hit_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      uni_hit_s[i] = (dest_s == D'(i));
    end
    case (kind_s)
      DEST_BCAST: in_ready_s = &can_acc_s;
      DEST_UNI:   in_ready_s = |(uni_hit_s & can_acc_s);
      DEST_BAD:   in_ready_s = 1'b1;
      default:    in_ready_s = 1'b0;
    endcase
    up_xfer_s = bus.up_in_valid & in_ready_s;
    case (kind_s)
      DEST_BCAST: load_s = {N{up_xfer_s}};
      DEST_UNI:   load_s = uni_hit_s & {N{up_xfer_s}};
      default:    load_s = {N{1'b0}};
    endcase
    drop_s = up_xfer_s & (kind_s == DEST_BAD);
  end

  // Per-channel one-entry output registers; load wins over drain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_r <= {N{1'b0}};
      out_data_r  <= {(N*W){1'b0}};
    end else begin
      for (int i = 0; i < N; i++) begin
        if (load_s[i]) begin
          out_valid_r[i]        <= 1'b1;
          out_data_r[i*W +: W]  <= bus.up_in_data;
        end else if (bus.ds_out_ready[i]) begin
          out_valid_r[i]        <= 1'b0;
        end
      end
    end
  end

  // Sticky illegal-destination flag and saturating drop counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bad_dest_r   <= 1'b0;
      drop_count_r <= {DC{1'b0}};
    end else if (drop_s) begin
      bad_dest_r <= 1'b1;
      if (drop_count_r != DROP_MAX) begin
        drop_count_r <= drop_count_r + DC'(1'b1);
      end
    end
  end

  assign up_can_acc_s = !up_valid_r || bus.up_out_ready;

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .req       (bus.ds_in_valid),
    .advance   (up_can_acc_s),
    .pointer   (ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  // Select the granted channel's data and stamp its index into the id field.
  always_comb begin
    sel_data_s = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      sel_data_s = sel_data_s | (bus.ds_in_data[i*W +: W] & {W{grant_s[i]}});
    end
    tagged_s = (sel_data_s & PAYLOAD_MASK) | (W'(grant_idx_s) << (W - D));
  end

  // Merged output register and round-robin pointer, advanced only on a transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up_valid_r <= 1'b0;
      up_data_r  <= {W{1'b0}};
      ptr_r      <= {IW{1'b0}};
    end else if (|grant_s) begin
      up_valid_r <= 1'b1;
      up_data_r  <= tagged_s;
      ptr_r      <= (grant_idx_s == IW'(N - 1)) ? {IW{1'b0}} : grant_idx_s + IW'(1'b1);
    end else if (bus.up_out_ready) begin
      up_valid_r <= 1'b0;
    end
  end

  // Status flags include the hub's own traffic so the master never sees a false quiet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flying_r <= 1'b0;
      odd_r    <= 1'b0;
    end else begin
      flying_r <= (|bus.ds_has_message_flying) | (|out_valid_r) | up_valid_r
                  | bus.up_in_valid | (|bus.ds_in_valid);
      odd_r    <= |bus.ds_has_odd_clusters;
    end
  end

  assign bus.up_in_ready        = in_ready_s;
  assign bus.ds_out_valid       = out_valid_r;
  assign bus.ds_out_data        = out_data_r;
  assign bus.ds_in_ready        = grant_s;
  assign bus.up_out_valid       = up_valid_r;
  assign bus.up_out_data        = up_data_r;
  assign bus.has_message_flying = flying_r;
  assign bus.has_odd_clusters   = odd_r;
  assign bus.bad_dest           = bad_dest_r;
  assign bus.drop_count         = drop_count_r;

endmodule

// File: doc/root_hub_router.md
Name: root_hub_router

Overview:
- Parametrised root-level message hub between the master stage controller and N downstream hub FIFO channels.
- Master to downstream: routes each message by its destination field, either broadcast to all channels or unicast to one channel.
- Downstream to master: merges messages with a round-robin arbiter and tags each with its source channel.
- Aggregates downstream has_message_flying / has_odd_clusters and folds in the hub's own in-flight state, so the master never sees a false "quiet".

Parameters:
- DOWNSTREAM_FIFO_COUNT, 4: number of downstream channels N (1..2^FIFO_IDWIDTH-1).
- HUB_FIFO_WIDTH, 32: message width W, including the destination field.
- FIFO_IDWIDTH, 4: destination/source field width D, located at bits [W-1:W-D].
- DROP_COUNT_WIDTH, 8: width of the bad-destination drop counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- up_in_data  in  W  message from the master.
- up_in_valid  in  1  master message valid.
- up_in_ready  out  1  hub can accept the master message.
- up_out_data  out  W  merged message to the master; field [W-1:W-D] holds the source channel index.
- up_out_valid  out  1  merged message valid.
- up_out_ready  in  1  master accepts the merged message.
- ds_out_data  out  N*W  per-channel outbound data; channel i at [i*W +: W].
- ds_out_valid  out  N  per-channel outbound valid.
- ds_out_ready  in  N  per-channel outbound ready.
- ds_in_data  in  N*W  per-channel inbound data.
- ds_in_valid  in  N  per-channel inbound valid.
- ds_in_ready  out  N  per-channel inbound ready.
- ds_has_message_flying  in  N  downstream busy flags.
- ds_has_odd_clusters  in  N  downstream odd-cluster flags.
- has_message_flying  out  1  aggregated busy flag to the master.
- has_odd_clusters  out  1  aggregated odd-cluster flag to the master.
- bad_dest  out  1  sticky: a message with an illegal destination was dropped.
- drop_count  out  DROP_COUNT_WIDTH  number of dropped messages; saturates at all-ones.

Behaviour:
- Reset: when reset is low, all of the following clear immediately (asynchronous), including mid-transfer; in-flight data is discarded.
  - Every ds_out_valid and up_out_valid.
  - has_message_flying, has_odd_clusters, bad_dest, drop_count.
  - Round-robin pointer set to 0.
- Handshake: valid/ready; a transfer occurs when both are high on a clock edge. A held valid keeps its data stable until the transfer.
- Outbound path (master to downstream):
  - Each channel has a one-entry output register. The register "can accept" if it is empty, or ds_out_ready[i] is high this cycle.
  - Destination dest = up_in_data[W-1:W-D].
  - Broadcast (dest all-ones): up_in_ready = AND of can-accept over all N channels. On transfer, every channel register loads the message unchanged.
  - Unicast (dest < N): up_in_ready = can-accept of channel dest. On transfer, only that channel loads.
  - Illegal (N <= dest < all-ones): up_in_ready = 1. The message is dropped, bad_dest is set, and drop_count increments (saturating at all-ones).
  - Latency: exactly 1 cycle from up_in transfer to ds_out_valid. Throughput: 1 message per cycle when downstream is ready.
- Inbound path (downstream to master):
  - One output register, which "can accept" if it is empty or up_out_ready is high.
  - Round-robin arbiter over ds_in_valid, starting the search at the pointer.
  - ds_in_ready[i] = (grant == i) and the output register can accept. Exactly one channel, or none, is ready per cycle.
  - On transfer: up_out_data = ds_in_data[i] with [W-1:W-D] overwritten by i. The pointer becomes (i+1) mod N; it is unchanged when no transfer occurs.
  - Latency: 1 cycle. Under full contention among k requesters, each requester is served once every k cycles.
- Status aggregation (registered, 1 cycle latency):
  - has_message_flying = OR(ds_has_message_flying) | any ds_out_valid | up_out_valid | up_in_valid | any ds_in_valid.
  - has_odd_clusters = OR(ds_has_odd_clusters).
- Simultaneous events: a load and a drain of the same register in one cycle give back-to-back throughput with no bubble. A broadcast that is blocked by one full channel stalls the master; no partial delivery occurs.

Decomposition:
- Package hub_router_pkg holds:
  - function dest_of(msg).
  - constant BROADCAST_ID = all-ones of FIFO_IDWIDTH.
  - enum {DEST_BCAST, DEST_UNI, DEST_BAD}.
- Sub-module rr_arbiter #(N): inputs req[N], advance, pointer; outputs one-hot grant and grant index.

Test Plan:
- Broadcast: N=4, all ds_out_ready=1, send 0xF0000055 → all 4 ds_out_valid high one cycle later with identical data; up_in_ready stays 1.
- Broadcast with backpressure: ds_out_ready=4'b1011 and channel 2 holding data, send a broadcast → up_in_ready=0 until channel 2 drains; then all 4 channels load in the same cycle.
- Unicast and illegal destination: dest=2 → only ds_out_valid[2] asserts. dest=5 → accepted, bad_dest=1, drop_count=1, no ds_out_valid change. 255 further illegal messages (with DROP_COUNT_WIDTH=8) → drop_count=255, saturated.
- Round-robin: ds_in_valid=4'b1111 held, up_out_ready=1 → source tags on up_out are 0,1,2,3,0 over consecutive cycles.
- Status: all ds flags low and all paths idle → has_message_flying=0. Raise ds_has_odd_clusters[3] → has_odd_clusters=1 on the next cycle. Hold up_out_valid with up_out_ready=0 → has_message_flying stays 1.
- Reset mid-transfer: assert reset (low) while ds_out_valid=4'b1111 → all valids, flags and counters read 0 before the next clock edge; after release, the pointer starts at channel 0.
